// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: pipeline stage indices,
// default field widths and the shadow-pipe entry layout.
package hazard_pkg;

  localparam int STG_GRF = 0;
  localparam int STG_E   = 1;
  localparam int STG_M   = 2;
  localparam int STG_W   = 3;

  localparam int REG_AW_DEF = 5;
  localparam int TNEW_W_DEF = 3;
  localparam int FWD_W      = 3;
  localparam int STAT_W     = 32;

  typedef struct packed {
    logic                  vld;
    logic [REG_AW_DEF-1:0] a3;
    logic [TNEW_W_DEF-1:0] tnew;
    logic [REG_AW_DEF-1:0] rs;
    logic [REG_AW_DEF-1:0] rt;
  } hz_entry_t;

endpackage

// File: rtl/hazard_scoreboard_md_busy_timer.sv
// MDU occupancy timer: loads the multiply or divide latency on a start and
// counts down to zero; busy covers the start cycle itself.
module md_busy_timer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // A start while already busy simply reloads: the latest operation owns HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0) | i_start;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: shadow pipe of pending GRF writes, D-stage
// stall, D/E forward selects, MDU busy. Define HAZARD_STAT_EN for stall_cnt.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH       = STG_W,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int TNEW_W      = TNEW_W_DEF,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_need_rs,
  input  logic              d_need_rt,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic              d_we,
  input  logic [REG_AW-1:0] d_a3,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_md_use,
  input  logic              e_md_start,
  input  logic              e_md_div,
  output logic              stall,
  output logic              md_busy,
  output logic [FWD_W-1:0]  fwd_rs_d,
  output logic [FWD_W-1:0]  fwd_rt_d,
  output logic [FWD_W-1:0]  fwd_rs_e,
  output logic [FWD_W-1:0]  fwd_rt_e,
  output logic [STAT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] a3;
    logic [TNEW_W-1:0] tnew;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } entry_t;

  typedef struct packed {
    logic              hit;
    logic [TNEW_W-1:0] tnew;
    logic [FWD_W-1:0]  stg;
  } match_t;

  entry_t r_pipe [1:DEPTH];
  match_t w_m_rs_d, w_m_rt_d, w_m_rs_e, w_m_rt_e;
  logic   w_stall_rs, w_stall_rt;

  function automatic entry_t age(input entry_t e);
    entry_t o;
    o      = e;
    o.tnew = (e.tnew == '0) ? '0 : e.tnew - 1'b1;
    return o;
  endfunction

  // Scan oldest to youngest so the youngest writer of r overrides older ones.
  function automatic match_t youngest(input logic [REG_AW-1:0] r, input int lo);
    match_t m;
    m = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (k >= lo && r != '0 && r_pipe[k].vld && r_pipe[k].a3 == r) begin
        m.hit  = 1'b1;
        m.tnew = r_pipe[k].tnew;
        m.stg  = FWD_W'(k);
      end
    end
    return m;
  endfunction

  assign w_m_rs_d = youngest(d_rs, STG_E);
  assign w_m_rt_d = youngest(d_rt, STG_E);
  assign w_m_rs_e = youngest(r_pipe[STG_E].rs, STG_M);
  assign w_m_rt_e = youngest(r_pipe[STG_E].rt, STG_M);

  assign w_stall_rs = d_need_rs && w_m_rs_d.hit && (w_m_rs_d.tnew > d_tuse_rs);
  assign w_stall_rt = d_need_rt && w_m_rt_d.hit && (w_m_rt_d.tnew > d_tuse_rt);
  assign stall      = w_stall_rs | w_stall_rt | (d_md_use & md_busy);

  // A match still in flight (tnew>0) reports GRF here; E-stage forwarding picks it up later.
  assign fwd_rs_d = (w_m_rs_d.hit && w_m_rs_d.tnew == '0) ? w_m_rs_d.stg : FWD_W'(STG_GRF);
  assign fwd_rt_d = (w_m_rt_d.hit && w_m_rt_d.tnew == '0) ? w_m_rt_d.stg : FWD_W'(STG_GRF);
  assign fwd_rs_e = (w_m_rs_e.hit && w_m_rs_e.tnew == '0) ? w_m_rs_e.stg : FWD_W'(STG_GRF);
  assign fwd_rt_e = (w_m_rt_e.hit && w_m_rt_e.tnew == '0) ? w_m_rt_e.stg : FWD_W'(STG_GRF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) r_pipe[k] <= '0;
    end else begin
      if (stall) begin
        r_pipe[STG_E] <= '0;
      end else begin
        r_pipe[STG_E] <= '{vld: d_we && (d_a3 != '0), a3: d_a3, tnew: d_tnew,
                           rs: d_rs, rt: d_rt};
      end
      for (int k = 2; k <= DEPTH; k++) r_pipe[k] <= age(r_pipe[k-1]);
    end
  end

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_timer (
    .clk     (clk),
    .reset   (reset),
    .i_start (e_md_start),
    .i_div   (e_md_div),
    .o_busy  (md_busy)
  );

`ifdef HAZARD_STAT_EN
  logic [STAT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (stall && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
